// File: rtl/core_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : core_seq
// Purpose  : Multi-cycle instruction sequencer. Walks each instruction
//            through FETCH -> DECODE -> (MEM) -> WB, keeps the PC and the
//            retired-instruction counter, and parks in a sticky HALT state
//            on ebreak, illegal instruction or handshake timeout.
// Ports    : sys_clk / sys_rst (async, active low)
//            ifu_req / ifu_valid / ifu_inst      - instruction fetch
//            inst, dec_*                         - decode feedback
//            dec_pc_wen / dec_pc_wdata           - branch / jump redirect
//            lsu_req / lsu_ack                   - load/store handshake
//            gpr_wen, pc, retire, instret,
//            halt, fault_code                    - commit and status
// Fault codes: 00 ebreak, 01 fetch timeout, 10 memory timeout, 11 illegal.
// Revision : 1.0 - initial release
// ============================================================================
module core_seq #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = XLEN'(32'h8000_0000),
    parameter int              TIMEOUT  = 255,
    parameter int              CNT_W    = 64
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    output logic             ifu_req,
    input  logic             ifu_valid,
    input  logic [31:0]      ifu_inst,
    output logic [31:0]      inst,
    input  logic             dec_illegal,
    input  logic             dec_ebreak,
    input  logic             dec_mem,
    input  logic             dec_gpr_wen,
    input  logic             dec_pc_wen,
    input  logic [XLEN-1:0]  dec_pc_wdata,
    output logic             lsu_req,
    input  logic             lsu_ack,
    output logic             gpr_wen,
    output logic [XLEN-1:0]  pc,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halt,
    output logic [1:0]       fault_code
);

    // Wide enough to hold TIMEOUT; the counter saturates so it never wraps
    // back into the timeout window.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    localparam logic [1:0] c_fault_ebreak  = 2'b00;
    localparam logic [1:0] c_fault_fetch   = 2'b01;
    localparam logic [1:0] c_fault_mem     = 2'b10;
    localparam logic [1:0] c_fault_illegal = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM    = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_inst;
    logic [CNT_W-1:0]  r_instret;
    logic [1:0]        r_fault;
    logic [1:0]        w_fault_next;
    logic [WAIT_W-1:0] r_wait;
    logic              w_retire;
    logic              w_timeout;

    // True during the last permitted wait cycle; a handshake in that same
    // cycle still wins because it is tested first below.
    assign w_timeout = (TIMEOUT > 0) && (r_wait == c_wait_last);

    always_comb begin
        w_state_next = r_state;
        w_fault_next = r_fault;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (ifu_valid) begin
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_state_next = S_HALT;
                    w_fault_next = c_fault_fetch;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    w_state_next = S_HALT;
                    w_fault_next = c_fault_illegal;
                end else if (dec_ebreak) begin
                    // ebreak counts as retired but never reaches WB, so the
                    // PC is left pointing at the ebreak itself.
                    w_state_next = S_HALT;
                    w_fault_next = c_fault_ebreak;
                    w_retire     = 1'b1;
                end else if (dec_mem) begin
                    w_state_next = S_MEM;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_ack) begin
                    w_state_next = S_WB;
                end else if (w_timeout) begin
                    w_state_next = S_HALT;
                    w_fault_next = c_fault_mem;
                end
            end
            S_WB: begin
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_HALT;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state   <= S_FETCH;
            r_pc      <= PC_RESET;
            r_inst    <= '0;
            r_instret <= '0;
            r_fault   <= '0;
            r_wait    <= '0;
        end else begin
            r_state <= w_state_next;
            r_fault <= w_fault_next;
            if ((r_state == S_FETCH) && ifu_valid) begin
                r_inst <= ifu_inst;
            end
            if (r_state == S_WB) begin
                r_pc <= dec_pc_wen ? dec_pc_wdata : (r_pc + XLEN'(4));
            end
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            // Any state change restarts the count, which covers every entry
            // into FETCH or MEM.
            if (w_state_next != r_state) begin
                r_wait <= '0;
            end else if (((r_state == S_FETCH) || (r_state == S_MEM)) && (r_wait != '1)) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    assign ifu_req    = (r_state == S_FETCH);
    assign lsu_req    = (r_state == S_MEM);
    assign halt       = (r_state == S_HALT);
    assign gpr_wen    = (r_state == S_WB) && dec_gpr_wen;
    assign retire     = w_retire;
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign instret    = r_instret;
    assign fault_code = r_fault;

endmodule
`default_nettype wire
